// File: rtl/rx_word_packer_pkg.sv
// Shared constants, FSM state type and byte-insertion helper for the
// receive-side word packer.
package rx_word_packer_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  // Comma/idle symbol shared with the serializer/deserializer benches
  localparam logic [BYTE_W-1:0] COMMA_SYM = 8'hBC;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } packState_t;

  // Places a byte into a word at the given byte index; index 0 is the
  // first received byte and lands in the most significant byte.
  function automatic logic [WORD_W-1:0] insertByte(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        idx,
    input logic [BYTE_W-1:0] b
  );
    logic [WORD_W-1:0] res;
    res = word;
    case (idx)
      2'd0:    res[31:24] = b;
      2'd1:    res[23:16] = b;
      2'd2:    res[15:8]  = b;
      default: res[7:0]   = b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rx_word_packer_fifo.sv
// Synchronous FIFO holding completed words. Full/empty are derived from an
// occupancy counter; a push while full is accepted only when a pop frees
// the head slot on the same edge.
module word_fifo import rx_word_packer_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);
  assign count    = r_count;
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && reset && (!full || w_doPop);
  assign dout     = empty ? '0 : r_mem[r_rdPtr];

  // Storage write; contents are don't-care until counted as occupied
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping, both pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_word_packer.sv
// Packs the deserializer's byte stream into 32-bit words (first byte in the
// MSB), queues them in a small FIFO, and reports fragments and overflow.
module rx_word_packer import rx_word_packer_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frag_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  packState_t        r_state;
  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_asm;
  logic              r_fragErr;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_wordCnt;

  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_word;
  logic              w_full;
  logic              w_empty;
  logic [FCW-1:0]    w_unusedCount;

  assign w_push    = (r_state == PACK) && valid_in && (r_idx == 2'd3);
  assign w_word    = insertByte(r_asm, 2'd3, data_in);
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign frag_err  = r_fragErr;
  assign overflow  = r_overflow;
  assign word_cnt  = r_wordCnt;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_word),
    .pop   (w_pop),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_unusedCount)
  );

  // Byte-assembly FSM: collects four valid bytes, drops a partial word on a gap
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_asm     <= '0;
      r_fragErr <= 1'b0;
    end else begin
      r_fragErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_asm   <= insertByte('0, 2'd0, data_in);
            r_idx   <= 2'd1;
            r_state <= PACK;
          end
        end
        PACK: begin
          if (!valid_in) begin
            r_fragErr <= 1'b1;
            r_idx     <= 2'd0;
            r_asm     <= '0;
            r_state   <= IDLE;
          end else if (r_idx == 2'd3) begin
            r_idx   <= 2'd0;
            r_asm   <= '0;
            r_state <= IDLE;
          end else begin
            r_asm <= insertByte(r_asm, r_idx, data_in);
            r_idx <= r_idx + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Word counter and sticky overflow flag, driven by the push outcome
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_wordCnt  <= '0;
    end else if (w_push) begin
      if (!w_full || w_pop) begin
        r_wordCnt <= r_wordCnt + CNT_W'(1);
      end else begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// Scenario-based bench for rx_word_packer: expected words are queued as the
// fourth byte of each word is driven and compared as the consumer pops them.
module tb_rx_word_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frag_err;
  logic        overflow;
  logic [15:0] word_cnt;

  logic [31:0] out_data2;
  logic        out_valid2;
  logic        frag_err2;
  logic        overflow2;
  logic [2:0]  word_cnt2;

  int          nCompared;
  int          nMismatched;
  logic [31:0] expQ [$];

  rx_word_packer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frag_err  (frag_err),
    .overflow  (overflow),
    .word_cnt  (word_cnt)
  );

  // Narrow-counter instance sharing the stimulus, used for the wrap check
  rx_word_packer #(.FIFO_DEPTH(4), .CNT_W(3)) dutNarrow (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .frag_err  (frag_err2),
    .overflow  (overflow2),
    .word_cnt  (word_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer side: every word about to be popped must match the queue head
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL pop_unexpected: got %h, required no word", out_data);
      end else begin
        logic [31:0] exp;
        exp = expQ.pop_front();
        if (out_data !== exp) begin
          nMismatched++;
          $display("[TB] FAIL pop_data: got %h, required %h", out_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    data_in  = b;
    valid_in = 1'b1;
    tick();
  endtask

  task automatic sendWord(input logic [31:0] w, input bit accepted);
    for (int b = 0; b < 4; b++) begin
      data_in  = w[31-8*b -: 8];
      valid_in = 1'b1;
      if (b == 3 && accepted) expQ.push_back(w);
      tick();
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] req);
    nCompared++;
    if (got !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic resetDut();
    valid_in  = 1'b0;
    out_ready = 1'b0;
    data_in   = 8'h00;
    checkVal("queue_drained", 32'(expQ.size()), 32'd0);
    expQ.delete();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    valid_in  = 1'b1;
    data_in   = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkVal("rst_out_data", out_data, 32'd0);
      checkVal("rst_frag_err", {31'd0, frag_err}, 32'd0);
      checkVal("rst_overflow", {31'd0, overflow}, 32'd0);
      checkVal("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    end
    reset    = 1'b1;
    valid_in = 1'b0;
    tick();
    sendWord(32'h12345678, 1'b1);
    valid_in = 1'b0;
    @(negedge clk);
    checkVal("first_out_valid", {31'd0, out_valid}, 32'd1);
    checkVal("first_out_data", out_data, 32'h12345678);
    checkVal("first_word_cnt", {16'd0, word_cnt}, 32'd1);
    tick();
  endtask

  task automatic test_back_to_back();
    resetDut();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in  = 8'(i);
      valid_in = 1'b1;
      if (i % 4 == 3) expQ.push_back({8'(i-3), 8'(i-2), 8'(i-1), 8'(i)});
      tick();
      @(negedge clk);
      checkVal("b2b_frag_err", {31'd0, frag_err}, 32'd0);
      checkVal("b2b_spacing", {31'd0, out_valid}, (i % 4 == 3) ? 32'd1 : 32'd0);
    end
    valid_in = 1'b0;
    checkVal("b2b_word_cnt", {16'd0, word_cnt}, 32'd4);
    tick();
    tick();
  endtask

  task automatic test_fragment();
    resetDut();
    out_ready = 1'b1;
    sendByte(8'hAA);
    sendByte(8'hBB);
    @(negedge clk);
    checkVal("frag_before_gap", {31'd0, frag_err}, 32'd0);
    valid_in = 1'b0;
    tick();
    @(negedge clk);
    checkVal("frag_pulse", {31'd0, frag_err}, 32'd1);
    sendByte(8'h01);
    @(negedge clk);
    checkVal("frag_pulse_end", {31'd0, frag_err}, 32'd0);
    sendByte(8'h02);
    sendByte(8'h03);
    expQ.push_back(32'h01020304);
    sendByte(8'h04);
    valid_in = 1'b0;
    @(negedge clk);
    checkVal("frag_out_data", out_data, 32'h01020304);
    checkVal("frag_word_cnt", {16'd0, word_cnt}, 32'd1);
    tick();
    tick();
  endtask

  task automatic test_overflow();
    resetDut();
    out_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      sendWord({4{4'(w), 4'(w)}}, w <= 4);
    end
    valid_in = 1'b0;
    @(negedge clk);
    checkVal("ovf_out_valid", {31'd0, out_valid}, 32'd1);
    checkVal("ovf_flag", {31'd0, overflow}, 32'd1);
    checkVal("ovf_word_cnt", {16'd0, word_cnt}, 32'd4);
    checkVal("ovf_head", out_data, 32'h11111111);
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checkVal("ovf_drained_valid", {31'd0, out_valid}, 32'd0);
    checkVal("ovf_drained_data", out_data, 32'd0);
    checkVal("ovf_sticky", {31'd0, overflow}, 32'd1);
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_full_push_pop();
    resetDut();
    out_ready = 1'b0;
    sendWord(32'hA0A0A0A1, 1'b1);
    sendWord(32'hA0A0A0A2, 1'b1);
    sendWord(32'hA0A0A0A3, 1'b1);
    sendWord(32'hA0A0A0A4, 1'b1);
    sendByte(8'hC5);
    sendByte(8'hC6);
    sendByte(8'hC7);
    out_ready = 1'b1;
    expQ.push_back(32'hC5C6C7C8);
    sendByte(8'hC8);
    out_ready = 1'b0;
    valid_in  = 1'b0;
    @(negedge clk);
    checkVal("fpp_overflow", {31'd0, overflow}, 32'd0);
    checkVal("fpp_word_cnt", {16'd0, word_cnt}, 32'd5);
    checkVal("fpp_head", out_data, 32'hA0A0A0A2);
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checkVal("fpp_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    resetDut();
    out_ready = 1'b1;
    sendByte(8'h01);
    sendByte(8'h02);
    reset    = 1'b0;
    data_in  = 8'h03;
    valid_in = 1'b1;
    tick();
    @(negedge clk);
    checkVal("midrst_frag", {31'd0, frag_err}, 32'd0);
    reset    = 1'b1;
    valid_in = 1'b0;
    tick();
    @(negedge clk);
    checkVal("midrst_no_frag", {31'd0, frag_err}, 32'd0);
    sendWord(32'hDEADBEEF, 1'b1);
    valid_in = 1'b0;
    @(negedge clk);
    checkVal("midrst_out_data", out_data, 32'hDEADBEEF);
    checkVal("midrst_word_cnt", {16'd0, word_cnt}, 32'd1);
    tick();
  endtask

  task automatic test_cnt_wrap();
    resetDut();
    out_ready = 1'b1;
    for (int w = 0; w < 7; w++) begin
      sendWord(32'h5A000000 | 32'(w), 1'b1);
    end
    valid_in = 1'b0;
    @(negedge clk);
    checkVal("wrap_cnt_max", {29'd0, word_cnt2}, 32'd7);
    sendWord(32'h5A0000FF, 1'b1);
    valid_in = 1'b0;
    @(negedge clk);
    checkVal("wrap_cnt_zero", {29'd0, word_cnt2}, 32'd0);
    checkVal("wrap_wide_cnt", {16'd0, word_cnt}, 32'd8);
    tick();
    tick();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b0;
    valid_in    = 1'b0;
    data_in     = 8'h00;
    out_ready   = 1'b0;
    test_reset();
    test_back_to_back();
    test_fragment();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_word();
    test_cnt_wrap();
    checkVal("final_queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
